// File: rtl/rx_video_depacket.sv
// Receive-side video depacketizer: validates the half-line packet header and
// unpacks (Y, C) byte pairs into 29-bit line-FIFO words with x/y tags.
module rx_video_depacket #(
    parameter logic [7:0]  MAGIC = 8'h5A,
    parameter int          NPIX  = 600,
    parameter logic [10:0] YMAX  = 11'd720
) (
    input  logic        i_clk_125M,
    input  logic        i_rst,
    input  logic        i_rx_en,
    input  logic [7:0]  i_rx_data,
    input  logic        i_fifo_full,
    output logic        o_fifo_wr,
    output logic [28:0] o_fifo_din,
    output logic [15:0] o_pkt_ok,
    output logic [15:0] o_pkt_err,
    output logic        o_ovf
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR1  = 3'd1;
    localparam logic [2:0] S_HDR2  = 3'd2;
    localparam logic [2:0] S_PIX_Y = 3'd3;
    localparam logic [2:0] S_PIX_C = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_DROP  = 3'd6;

    logic [2:0]  state;
    logic        prev_en;
    logic [1:0]  x;
    logic [2:0]  y_hi;
    logic [10:0] y;
    logic [7:0]  y_byte;
    logic [9:0]  pix_cnt;

    // prev_en clears in reset so a high i_rx_en right after release is a start
    always_ff @(posedge i_clk_125M) begin
        if (i_rst) begin
            state      <= S_IDLE;
            prev_en    <= 1'b0;
            x          <= 2'd0;
            y_hi       <= 3'd0;
            y          <= 11'd0;
            y_byte     <= 8'd0;
            pix_cnt    <= 10'd0;
            o_fifo_wr  <= 1'b0;
            o_fifo_din <= 29'd0;
            o_pkt_ok   <= 16'd0;
            o_pkt_err  <= 16'd0;
            o_ovf      <= 1'b0;
        end else begin
            prev_en   <= i_rx_en;
            o_fifo_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_rx_en && !prev_en) begin
                        if (i_rx_data == MAGIC) begin
                            state <= S_HDR1;
                        end else begin
                            state     <= S_DROP;
                            o_pkt_err <= o_pkt_err + 16'd1;
                        end
                    end
                end
                S_HDR1, S_HDR2, S_PIX_Y, S_PIX_C: begin
                    // run ended early: already-written words stay in the FIFO
                    if (!i_rx_en) begin
                        state     <= S_IDLE;
                        o_pkt_err <= o_pkt_err + 16'd1;
                    end else begin
                        case (state)
                            S_HDR1: begin
                                x     <= i_rx_data[7:6];
                                y_hi  <= i_rx_data[2:0];
                                state <= S_HDR2;
                            end
                            S_HDR2: begin
                                if ({y_hi, i_rx_data} >= YMAX) begin
                                    state     <= S_DROP;
                                    o_pkt_err <= o_pkt_err + 16'd1;
                                end else begin
                                    y       <= {y_hi, i_rx_data};
                                    pix_cnt <= 10'd0;
                                    state   <= S_PIX_Y;
                                end
                            end
                            S_PIX_Y: begin
                                y_byte <= i_rx_data;
                                state  <= S_PIX_C;
                            end
                            default: begin
                                if (i_fifo_full) begin
                                    o_ovf <= 1'b1;
                                    state <= S_DROP;
                                end else begin
                                    o_fifo_wr  <= 1'b1;
                                    o_fifo_din <= {x, y, y_byte, i_rx_data};
                                    pix_cnt    <= pix_cnt + 10'd1;
                                    if (pix_cnt == 10'(NPIX - 1)) begin
                                        state    <= S_DONE;
                                        o_pkt_ok <= o_pkt_ok + 16'd1;
                                    end else begin
                                        state <= S_PIX_Y;
                                    end
                                end
                            end
                        endcase
                    end
                end
                S_DONE, S_DROP: begin
                    if (!i_rx_en) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rx_video_depacket.md
# rx_video_depacket

Receive-side depacketizer for the Ethernet video path. It takes the stripped UDP payload byte stream for one half-line video packet. It checks the header and unpacks 4:2:2 YCbCr pixel pairs into 29-bit words `{x_count[1:0], y_count[10:0], Y[7:0], C[7:0]}`. It writes those words into the line FIFO that the display-side pixel data controller drains during the active area.

## Interface
Parameters:
- `MAGIC`, 8'h5A: required first payload byte.
- `NPIX`, 600: pixels per packet, i.e. half of a 1200-pixel active line.
- `YMAX`, 11'd720: highest legal line number plus one. A header with `y >= YMAX` is a header error.

Ports:
- `i_clk_125M`  in  1: receive-side byte clock. The only clock in the block.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_rx_en`  in  1: payload byte valid. One packet is one contiguous high run.
- `i_rx_data`  in  8: payload byte.
- `i_fifo_full`  in  1: line FIFO full (write side).
- `o_fifo_wr`  out  1: FIFO write strobe, one cycle per word.
- `o_fifo_din`  out  29: `{x_count[1:0], y_count[10:0], Y[7:0], C[7:0]}`.
- `o_pkt_ok`  out  16: count of complete, error-free packets. Wraps.
- `o_pkt_err`  out  16: count of bad-magic, bad-y and short packets. Wraps.
- `o_ovf`  out  1: sticky FIFO overflow. Cleared only by `i_rst`.

## Operation
- Packet layout, in byte order:
  - byte0: MAGIC.
  - byte1: `{x[1:0], 3'b000, y[10:8]}`.
  - byte2: `y[7:0]`.
  - Then NPIX pairs of (Y, C). C alternates Cr/Cb; the consumer tracks the phase.
- Packet start: the cycle `i_rx_en` is high after being low, or the first high cycle after reset release.
- States:
  - IDLE: a start byte moves to HDR1 if the byte equals MAGIC. Otherwise it moves to DROP and counts an error.
  - HDR1: latch x, y_hi; move to HDR2.
  - HDR2: latch y_lo. If `y >= YMAX`, move to DROP and count an error; otherwise move to PIX_Y with the pixel counter set to 0.
  - PIX_Y: latch Y; move to PIX_C.
  - PIX_C: form the word from the latched x, y, Y and the current byte, and issue a write. Increment the pixel counter. When it reaches NPIX, move to DONE; otherwise move back to PIX_Y.
  - DONE: increment `o_pkt_ok` once, on entry. Any further bytes in the run are ignored. Return to IDLE when `i_rx_en` falls.
  - DROP: ignore bytes until `i_rx_en` is low, then return to IDLE.
- Short packet: `i_rx_en` low in any state from HDR1 through PIX_C.
  - Count `o_pkt_err` once and go to IDLE.
  - Words already written stay in the FIFO; there is no rollback.
  - A lone Y byte left in PIX_Y is discarded.
- FIFO full when a word is due:
  - The word is not written and `o_ovf` is set.
  - The state goes to DROP. The packet is counted in neither `o_pkt_ok` nor `o_pkt_err`.
- The pixel counter is 10 bits. x and y are held constant for the whole packet.
- Simultaneous events: a new start byte on the same cycle DROP or DONE sees `i_rx_en` low cannot occur, because a start needs a low cycle first. The minimum inter-packet gap is 1 cycle.

## Timing
- `o_fifo_din` and `o_fifo_wr` are registered. The write appears 1 cycle after the C byte is accepted, and `o_fifo_wr` is high for exactly 1 cycle.
- `i_fifo_full` is sampled on the C-byte cycle.
- Counter and `o_ovf` updates are visible 1 cycle after their cause.
- Maximum write rate is one word per 2 cycles. A full packet is 3 + 2·NPIX bytes, which is 1203 at the defaults.
- Reset:
  - State goes to IDLE.
  - `o_fifo_wr`=0, `o_fifo_din`=0, `o_pkt_ok`=0, `o_pkt_err`=0, `o_ovf`=0.
  - Reset mid-packet aborts the packet without counting it.
  - After release, the first packet must start on a fresh rising edge of `i_rx_en`, or on the first high cycle if `i_rx_en` is already high. Any remainder of an interrupted packet is treated as a start byte and normally lands in DROP via the magic check.

## Test plan
- Good packet: x=1, y=37, NPIX pairs with Y=k, C=255-k.
  - Expect 600 writes with `o_fifo_din = {2'd1, 11'd37, k, 255-k}`.
  - Each write lands 1 cycle after its C byte.
  - `o_pkt_ok`=1, `o_pkt_err`=0.
- Bad header:
  - First byte 8'hA5: expect no writes and `o_pkt_err`=1.
  - Next packet with y=720: expect no writes and `o_pkt_err`=2.
- Short packet: `i_rx_en` drops after 3+2·10+1 bytes.
  - Expect exactly 10 writes and `o_pkt_err`=1.
  - The following good packet is fully accepted.
- Overflow: `i_fifo_full` asserted on the 5th C byte.
  - Expect 4 writes, then `o_ovf`=1 and no further writes for that packet.
  - Both counters unchanged. `o_ovf` stays 1 through the next good packet.
- Trailing bytes: a packet with 4 extra bytes after the last pair.
  - Expect 600 writes and `o_pkt_ok`=1.
  - The extra bytes cause no writes.
- Mid-packet reset: `i_rst` pulsed during pixel 300.
  - Expect all outputs to be 0 on the next cycle.
  - A subsequent clean packet gives 600 writes and `o_pkt_ok`=1.
